score_char_gen: RTL and testbench

- Responder side of the score-text font interface used by the score overlay drawer.
- The drawer issues a character cell address (char_yx_score) and a glyph line (char_line_score). This block returns the 40-pixel row (char_pixels_score) exactly 2 pclk later, aligned with the drawer's delay pipeline.
- Owns the 4-digit BCD score counter. Selects the banner text (SCORE / GAME OVER / YOU WIN!), latched once per frame so nothing tears mid-frame.

---
 rtl/score_text_pkg.sv | 107 ++++++++++
 rtl/score_char_gen_if.sv | 21 ++
 rtl/score_char_gen_font_rom.sv | 48 ++++
 rtl/score_char_gen.sv | 131 +++++++++++++
 tb/tb_score_char_gen.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_text_pkg.sv
// Shared constants for the score text overlay: character codes, banner strings,
// display modes, 8x8 glyph bitmaps and small helper functions.
package score_text_pkg;

    localparam int unsigned NUM_COLS  = 14;
    localparam int unsigned SCALE     = 5;
    localparam int unsigned CHAR_W    = 8 * SCALE;
    // BCD saturation value (decimal 9999)
    localparam logic [15:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        ModeNormal   = 2'd0,
        ModeGameOver = 2'd1,
        ModeVictory  = 2'd2
    } mode_e;

    typedef logic [4:0] char_code_t;

    localparam char_code_t CH_BLANK = 5'd0;
    localparam char_code_t CH_D0    = 5'd1;  // digits occupy CH_D0 .. CH_D0+9
    localparam char_code_t CH_A     = 5'd11;
    localparam char_code_t CH_C     = 5'd12;
    localparam char_code_t CH_E     = 5'd13;
    localparam char_code_t CH_G     = 5'd14;
    localparam char_code_t CH_I     = 5'd15;
    localparam char_code_t CH_M     = 5'd16;
    localparam char_code_t CH_N     = 5'd17;
    localparam char_code_t CH_O     = 5'd18;
    localparam char_code_t CH_R     = 5'd19;
    localparam char_code_t CH_S     = 5'd20;
    localparam char_code_t CH_U     = 5'd21;
    localparam char_code_t CH_V     = 5'd22;
    localparam char_code_t CH_W     = 5'd23;
    localparam char_code_t CH_Y     = 5'd24;
    localparam char_code_t CH_BANG  = 5'd25;

    // Columns 10..13 are overwritten by the score digits.
    localparam char_code_t TXT_NORMAL [NUM_COLS] = '{
        CH_S, CH_C, CH_O, CH_R, CH_E, CH_BLANK, CH_BLANK,
        CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK
    };
    localparam char_code_t TXT_GAME_OVER [NUM_COLS] = '{
        CH_G, CH_A, CH_M, CH_E, CH_BLANK, CH_O, CH_V,
        CH_E, CH_R, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK
    };
    localparam char_code_t TXT_VICTORY [NUM_COLS] = '{
        CH_Y, CH_O, CH_U, CH_BLANK, CH_W, CH_I, CH_N,
        CH_BANG, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK
    };

    // Glyph bitmaps, row 0 in the top byte, bit 7 = leftmost pixel.
    localparam logic [63:0] GLYPH_D0   = 64'h3C66_6E76_6666_3C00;
    localparam logic [63:0] GLYPH_D1   = 64'h1838_1818_1818_7E00;
    localparam logic [63:0] GLYPH_D2   = 64'h3C66_060C_3060_7E00;
    localparam logic [63:0] GLYPH_D3   = 64'h3C66_061C_0666_3C00;
    localparam logic [63:0] GLYPH_D4   = 64'h0C1C_3C6C_7E0C_0C00;
    localparam logic [63:0] GLYPH_D5   = 64'h7E60_7C06_0666_3C00;
    localparam logic [63:0] GLYPH_D6   = 64'h3C60_7C66_6666_3C00;
    localparam logic [63:0] GLYPH_D7   = 64'h7E06_0C18_3030_3000;
    localparam logic [63:0] GLYPH_D8   = 64'h3C66_663C_6666_3C00;
    localparam logic [63:0] GLYPH_D9   = 64'h3C66_663E_060C_3800;
    localparam logic [63:0] GLYPH_A    = 64'h183C_6666_7E66_6600;
    localparam logic [63:0] GLYPH_C    = 64'h3C66_6060_6066_3C00;
    localparam logic [63:0] GLYPH_E    = 64'h7E60_6078_6060_7E00;
    localparam logic [63:0] GLYPH_G    = 64'h3C66_606E_6666_3C00;
    localparam logic [63:0] GLYPH_I    = 64'h3C18_1818_1818_3C00;
    localparam logic [63:0] GLYPH_M    = 64'h6377_7F6B_6363_6300;
    localparam logic [63:0] GLYPH_N    = 64'h6676_7E7E_6E66_6600;
    localparam logic [63:0] GLYPH_O    = 64'h3C66_6666_6666_3C00;
    localparam logic [63:0] GLYPH_R    = 64'h7C66_667C_786C_6600;
    localparam logic [63:0] GLYPH_S    = 64'h3C66_603C_0666_3C00;
    localparam logic [63:0] GLYPH_U    = 64'h6666_6666_6666_3C00;
    localparam logic [63:0] GLYPH_V    = 64'h6666_6666_663C_1800;
    localparam logic [63:0] GLYPH_W    = 64'h6363_636B_7F77_6300;
    localparam logic [63:0] GLYPH_Y    = 64'h6666_663C_1818_1800;
    localparam logic [63:0] GLYPH_BANG = 64'h1818_1818_0000_1800;

    // Four-digit BCD increment with decimal carry; caller handles saturation.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Replicate each glyph bit SCALE times horizontally.
    function automatic logic [CHAR_W-1:0] expand_row(input logic [7:0] b);
        logic [CHAR_W-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[CHAR_W - 1 - SCALE * k -: SCALE] = {SCALE{b[7-k]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/score_char_gen_if.sv
// Font request/response bus between the overlay drawer and the score text generator.
interface score_char_gen_if;
    import score_text_pkg::*;

    logic [7:0]        char_yx_score;
    logic [7:0]        char_line_score;
    logic [CHAR_W-1:0] char_pixels_score;

    modport master (
        output char_yx_score,
        output char_line_score,
        input  char_pixels_score
    );

    modport slave (
        input  char_yx_score,
        input  char_line_score,
        output char_pixels_score
    );

endinterface

// File: rtl/score_char_gen_font_rom.sv
// Combinational 8x8 font ROM: (character code, glyph row) -> 8 pixel bits.
module score_font_rom
    import score_text_pkg::*;
(
    input  char_code_t code_i,
    input  logic [2:0] row_i,
    output logic [7:0] bits_o
);

    logic [63:0] glyph;
    logic [63:0] glyph_sh;

    // Pick the glyph bitmap, then shift the requested row into the top byte.
    always_comb begin
        glyph = '0;
        case (code_i)
            CH_D0:          glyph = GLYPH_D0;
            CH_D0 + 5'd1:   glyph = GLYPH_D1;
            CH_D0 + 5'd2:   glyph = GLYPH_D2;
            CH_D0 + 5'd3:   glyph = GLYPH_D3;
            CH_D0 + 5'd4:   glyph = GLYPH_D4;
            CH_D0 + 5'd5:   glyph = GLYPH_D5;
            CH_D0 + 5'd6:   glyph = GLYPH_D6;
            CH_D0 + 5'd7:   glyph = GLYPH_D7;
            CH_D0 + 5'd8:   glyph = GLYPH_D8;
            CH_D0 + 5'd9:   glyph = GLYPH_D9;
            CH_A:           glyph = GLYPH_A;
            CH_C:           glyph = GLYPH_C;
            CH_E:           glyph = GLYPH_E;
            CH_G:           glyph = GLYPH_G;
            CH_I:           glyph = GLYPH_I;
            CH_M:           glyph = GLYPH_M;
            CH_N:           glyph = GLYPH_N;
            CH_O:           glyph = GLYPH_O;
            CH_R:           glyph = GLYPH_R;
            CH_S:           glyph = GLYPH_S;
            CH_U:           glyph = GLYPH_U;
            CH_V:           glyph = GLYPH_V;
            CH_W:           glyph = GLYPH_W;
            CH_Y:           glyph = GLYPH_Y;
            CH_BANG:        glyph = GLYPH_BANG;
            default:        glyph = '0;
        endcase
        glyph_sh = glyph << {row_i, 3'b000};
        bits_o   = glyph_sh[63:56];
    end

endmodule

// File: rtl/score_char_gen.sv
// Score text character generator: BCD score counter, per-frame banner/score latch
// and a two-stage pipeline from cell address to 40-pixel row.
module score_char_gen
    import score_text_pkg::*;
(
    input  logic              pclk,
    input  logic              rst,
    score_char_gen_if.slave   font,
    input  logic              score_inc,
    input  logic              score_clr,
    input  logic              vsync_in,
    input  logic              game_over_in,
    input  logic              victory_in,
    output logic [15:0]       score_bcd
);

    logic [15:0]       score_q, score_d;
    logic [15:0]       disp_q, disp_d;
    mode_e             mode_q, mode_d;
    logic              vsync_q;
    logic              vsync_rise;

    char_code_t        code_q, code_d;
    logic [2:0]        grow_q, grow_d;
    logic [7:0]        glyph_bits;
    logic [CHAR_W-1:0] pix_q, pix_d;

    logic [3:0]        cell_row;
    logic [3:0]        cell_col;
    logic [3:0]        nib;

    assign cell_row   = font.char_yx_score[7:4];
    assign cell_col   = font.char_yx_score[3:0];
    assign vsync_rise = vsync_in & ~vsync_q;

    // Score counter: clear wins, increment saturates at 9999.
    always_comb begin
        score_d = score_q;
        if (score_clr) begin
            score_d = '0;
        end else if (score_inc && (score_q != SCORE_MAX)) begin
            score_d = bcd_inc(score_q);
        end
    end

    // Frame latch: display copy and banner mode only move on a vsync rising edge.
    always_comb begin
        disp_d = disp_q;
        mode_d = mode_q;
        if (vsync_rise) begin
            disp_d = score_q;
            if (game_over_in) begin
                mode_d = ModeGameOver;
            end else if (victory_in) begin
                mode_d = ModeVictory;
            end else begin
                mode_d = ModeNormal;
            end
        end
    end

    // Stage 1 next-state: character code and glyph row for the requested cell.
    always_comb begin
        code_d = CH_BLANK;
        grow_d = '0;
        nib    = '0;
        if ((cell_row == 4'd0) && (cell_col < 4'(NUM_COLS)) &&
            (font.char_line_score < 8'(CHAR_W))) begin
            grow_d = 3'(font.char_line_score / 8'(SCALE));
            case (cell_col)
                4'd10:   nib = disp_q[15:12];
                4'd11:   nib = disp_q[11:8];
                4'd12:   nib = disp_q[7:4];
                4'd13:   nib = disp_q[3:0];
                default: nib = '0;
            endcase
            if (cell_col >= 4'd10) begin
                code_d = CH_D0 + 5'(nib);
            end else begin
                case (mode_q)
                    ModeGameOver: code_d = TXT_GAME_OVER[cell_col];
                    ModeVictory:  code_d = TXT_VICTORY[cell_col];
                    default:      code_d = TXT_NORMAL[cell_col];
                endcase
            end
        end
    end

    score_font_rom u_font_rom (
        .code_i (code_q),
        .row_i  (grow_q),
        .bits_o (glyph_bits)
    );

    // Stage 2 next-state: horizontal pixel replication of the glyph row.
    always_comb begin
        pix_d = expand_row(glyph_bits);
    end

    // Score, frame-latch and vsync edge-detector registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            score_q <= '0;
            disp_q  <= '0;
            mode_q  <= ModeNormal;
            vsync_q <= 1'b0;
        end else begin
            score_q <= score_d;
            disp_q  <= disp_d;
            mode_q  <= mode_d;
            vsync_q <= vsync_in;
        end
    end

    // Pixel pipeline registers (stage 1 code/row, stage 2 output row).
    always_ff @(posedge pclk) begin
        if (rst) begin
            code_q <= CH_BLANK;
            grow_q <= '0;
            pix_q  <= '0;
        end else begin
            code_q <= code_d;
            grow_q <= grow_d;
            pix_q  <= pix_d;
        end
    end

    assign font.char_pixels_score = pix_q;
    assign score_bcd              = score_q;

endmodule

// File: tb/tb_score_char_gen.sv
// Directed self-checking bench for score_char_gen.
module tb_score_char_gen;

    logic        pclk;
    logic        rst;
    logic        score_inc;
    logic        score_clr;
    logic        vsync_in;
    logic        game_over_in;
    logic        victory_in;
    logic [15:0] score_bcd;

    int checks;
    int errors;

    score_char_gen_if font_if ();

    score_char_gen dut (
        .pclk         (pclk),
        .rst          (rst),
        .font         (font_if.slave),
        .score_inc    (score_inc),
        .score_clr    (score_clr),
        .vsync_in     (vsync_in),
        .game_over_in (game_over_in),
        .victory_in   (victory_in),
        .score_bcd    (score_bcd)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Hand-written reference glyphs (row 0 in the top byte).
    localparam logic [63:0] REF_0 = 64'h3C66_6E76_6666_3C00;
    localparam logic [63:0] REF_2 = 64'h3C66_060C_3060_7E00;
    localparam logic [63:0] REF_4 = 64'h0C1C_3C6C_7E0C_0C00;

    function automatic logic [7:0] ref_row(input logic [63:0] g, input int r);
        logic [63:0] s;
        s = g << (8 * r);
        return s[63:56];
    endfunction

    function automatic logic [39:0] ref_expand(input logic [7:0] b);
        logic [39:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < 5; p++) begin
                r[39 - 5 * k - p] = b[7 - k];
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic vsync_edge();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
    endtask

    // Present one address and wait out the two-cycle latency.
    task automatic fetch(input logic [7:0] yx, input logic [7:0] line);
        font_if.char_yx_score   = yx;
        font_if.char_line_score = line;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (score_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_score got %h want 0000", score_bcd);
        end
        checks++;
        if (font_if.char_pixels_score !== 40'h0) begin
            errors++;
            $display("FAIL reset_pixels got %h want 0", font_if.char_pixels_score);
        end
    endtask

    task automatic test_first_digit();
        vsync_edge();
        fetch(8'h0A, 8'd0);
        checks++;
        if (font_if.char_pixels_score !== 40'h00_3FFF_FC00) begin
            errors++;
            $display("FAIL digit0_row0 got %h want 003ffffc00", font_if.char_pixels_score);
        end
        // NORMAL banner col 0 is 'S', row 3 = 3C
        fetch(8'h00, 8'd15);
        checks++;
        if (font_if.char_pixels_score !== ref_expand(8'h3C)) begin
            errors++;
            $display("FAIL normal_S got %h want %h", font_if.char_pixels_score,
                     ref_expand(8'h3C));
        end
    endtask

    task automatic test_count();
        score_inc = 1'b1;
        for (int i = 0; i < 42; i++) tick();
        score_inc = 1'b0;
        checks++;
        if (score_bcd !== 16'h0042) begin
            errors++;
            $display("FAIL count42 got %h want 0042", score_bcd);
        end
        vsync_edge();
        for (int l = 0; l < 40; l++) begin
            fetch(8'h0C, 8'(l));
            checks++;
            if (font_if.char_pixels_score !== ref_expand(ref_row(REF_4, l / 5))) begin
                errors++;
                $display("FAIL col12_line%0d got %h want %h", l, font_if.char_pixels_score,
                         ref_expand(ref_row(REF_4, l / 5)));
            end
            fetch(8'h0D, 8'(l));
            checks++;
            if (font_if.char_pixels_score !== ref_expand(ref_row(REF_2, l / 5))) begin
                errors++;
                $display("FAIL col13_line%0d got %h want %h", l, font_if.char_pixels_score,
                         ref_expand(ref_row(REF_2, l / 5)));
            end
        end
    endtask

    task automatic test_saturate();
        score_clr = 1'b1;
        tick();
        score_clr = 1'b0;
        score_inc = 1'b1;
        for (int i = 1; i <= 9998; i++) begin
            tick();
            if (i == 10) begin
                checks++;
                if (score_bcd !== 16'h0010) begin
                    errors++;
                    $display("FAIL carry_10 got %h want 0010", score_bcd);
                end
            end
            if (i == 1000) begin
                checks++;
                if (score_bcd !== 16'h1000) begin
                    errors++;
                    $display("FAIL carry_1000 got %h want 1000", score_bcd);
                end
            end
        end
        checks++;
        if (score_bcd !== 16'h9998) begin
            errors++;
            $display("FAIL preload_9998 got %h want 9998", score_bcd);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (score_bcd !== 16'h9999) begin
            errors++;
            $display("FAIL sat_9999 got %h want 9999", score_bcd);
        end
        tick();
        checks++;
        if (score_bcd !== 16'h9999) begin
            errors++;
            $display("FAIL sat_hold got %h want 9999", score_bcd);
        end
        score_clr = 1'b1;
        tick();
        score_clr = 1'b0;
        score_inc = 1'b0;
        checks++;
        if (score_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL clr_with_inc got %h want 0000", score_bcd);
        end
    endtask

    task automatic test_mode();
        game_over_in = 1'b1;
        victory_in   = 1'b1;
        vsync_edge();
        fetch(8'h00, 8'd0);
        checks++;
        if (font_if.char_pixels_score !== ref_expand(8'h3C)) begin
            errors++;
            $display("FAIL gameover_G_row0 got %h want %h", font_if.char_pixels_score,
                     ref_expand(8'h3C));
        end
        fetch(8'h00, 8'd15);
        checks++;
        if (font_if.char_pixels_score !== ref_expand(8'h6E)) begin
            errors++;
            $display("FAIL gameover_G_row3 got %h want %h", font_if.char_pixels_score,
                     ref_expand(8'h6E));
        end
        // Flags change mid-frame without an edge: banner must not move.
        game_over_in = 1'b0;
        fetch(8'h00, 8'd15);
        checks++;
        if (font_if.char_pixels_score !== ref_expand(8'h6E)) begin
            errors++;
            $display("FAIL midframe_hold got %h want %h", font_if.char_pixels_score,
                     ref_expand(8'h6E));
        end
        vsync_edge();
        victory_in = 1'b0;
        fetch(8'h00, 8'd0);
        checks++;
        if (font_if.char_pixels_score !== ref_expand(8'h66)) begin
            errors++;
            $display("FAIL victory_Y_row0 got %h want %h", font_if.char_pixels_score,
                     ref_expand(8'h66));
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] yx [3];
        logic [7:0] ln [3];
        yx = '{8'h10, 8'h0E, 8'h0A};
        ln = '{8'd0, 8'd0, 8'd40};
        for (int i = 0; i < 3; i++) begin
            fetch(8'h00, 8'd0);
            fetch(yx[i], ln[i]);
            checks++;
            if (font_if.char_pixels_score !== 40'h0) begin
                errors++;
                $display("FAIL range_yx%h_line%0d got %h want 0", yx[i], ln[i],
                         font_if.char_pixels_score);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Mode is VICTORY, display score 0000.
        logic [7:0]  yx  [6];
        logic [7:0]  ln  [6];
        logic [39:0] exp [6];
        yx  = '{8'h00, 8'h07, 8'h0A, 8'h10, 8'h01, 8'h04};
        ln  = '{8'd0, 8'd0, 8'd5, 8'd0, 8'd30, 8'd15};
        exp = '{ref_expand(8'h66), ref_expand(8'h18), ref_expand(ref_row(REF_0, 1)),
                40'h0, ref_expand(8'h3C), ref_expand(8'h6B)};
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                font_if.char_yx_score   = yx[i];
                font_if.char_line_score = ln[i];
            end
            tick();
            if (i >= 1) begin
                checks++;
                if (font_if.char_pixels_score !== exp[i-1]) begin
                    errors++;
                    $display("FAIL b2b_%0d got %h want %h", i - 1, font_if.char_pixels_score,
                             exp[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        score_inc = 1'b1;
        tick();
        tick();
        tick();
        score_inc = 1'b0;
        fetch(8'h00, 8'd0);
        checks++;
        if (font_if.char_pixels_score !== ref_expand(8'h66)) begin
            errors++;
            $display("FAIL pre_reset_Y got %h want %h", font_if.char_pixels_score,
                     ref_expand(8'h66));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (font_if.char_pixels_score !== 40'h0) begin
            errors++;
            $display("FAIL midreset_pixels got %h want 0", font_if.char_pixels_score);
        end
        checks++;
        if (score_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_score got %h want 0000", score_bcd);
        end
        fetch(8'h00, 8'd15);
        checks++;
        if (font_if.char_pixels_score !== ref_expand(8'h3C)) begin
            errors++;
            $display("FAIL midreset_mode got %h want %h", font_if.char_pixels_score,
                     ref_expand(8'h3C));
        end
        fetch(8'h0D, 8'd5);
        checks++;
        if (font_if.char_pixels_score !== ref_expand(8'h66)) begin
            errors++;
            $display("FAIL midreset_disp got %h want %h", font_if.char_pixels_score,
                     ref_expand(8'h66));
        end
    endtask

    initial begin
        checks                  = 0;
        errors                  = 0;
        rst                     = 1'b1;
        score_inc               = 1'b0;
        score_clr               = 1'b0;
        vsync_in                = 1'b0;
        game_over_in            = 1'b0;
        victory_in              = 1'b0;
        font_if.char_yx_score   = 8'h00;
        font_if.char_line_score = 8'h00;

        test_reset();
        test_first_digit();
        test_count();
        test_saturate();
        test_mode();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
